// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet load controller: register map, FSM states,
// default buffer depths and buffer address widths.
package lenet_pkg;

  localparam int N_WGT_DEF  = 3220;
  localparam int N_BIAS_DEF = 10;
  localparam int N_PIX_DEF  = 784;

  localparam int WGT_AW  = 12;
  localparam int BIAS_AW = 4;
  localparam int PIX_AW  = 10;

  localparam logic [4:0] OFS_CTRL    = 5'h00;
  localparam logic [4:0] OFS_WGT     = 5'h04;
  localparam logic [4:0] OFS_BIAS    = 5'h08;
  localparam logic [4:0] OFS_PIX     = 5'h0C;
  localparam logic [4:0] OFS_STATUS  = 5'h10;
  localparam logic [4:0] OFS_DONE    = 5'h14;
  localparam logic [4:0] OFS_RESULT  = 5'h18;
  localparam logic [4:0] OFS_SOFTRST = 5'h1C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [31:0] pack_status(input logic wgt_full, input logic bias_full,
                                              input logic pix_full, input logic busy,
                                              input logic overflow_err);
    return {27'd0, overflow_err, busy, pix_full, bias_full, wgt_full};
  endfunction

endpackage

// File: rtl/lenet_stream_ch.sv
// One buffer-load channel: counts accepted stream words, emits a one-cycle
// buffer write at the current count and flags writes that arrive when full.
module lenet_stream_ch
  import lenet_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          clr_cnt,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic [AW-1:0] count,
  output logic          full,
  output logic          overflow
);

  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

  logic [AW-1:0] count_reg;

  assign count = count_reg;
  assign full  = (count_reg == DEPTH_C);

  // clr is the software-held reset; it returns everything to the power-up state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      we        <= 1'b0;
      addr      <= '0;
      data      <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      count_reg <= '0;
      we        <= 1'b0;
      addr      <= '0;
      data      <= '0;
      overflow  <= 1'b0;
    end else begin
      we <= 1'b0;
      if (clr_cnt) begin
        count_reg <= '0;
      end else if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          we        <= 1'b1;
          addr      <= count_reg;
          data      <= din;
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lenet_load_ctrl.sv
// Register-mapped loader for the LeNet core: streams weights, biases and an
// image into their buffers, launches the core and captures the classified digit.
module lenet_load_ctrl
  import lenet_pkg::*;
#(
  parameter int N_WGT  = N_WGT_DEF,
  parameter int N_BIAS = N_BIAS_DEF,
  parameter int N_PIX  = N_PIX_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                reg_wr,
  input  logic [4:0]          reg_waddr,
  input  logic [31:0]         reg_wdata,
  input  logic                reg_rd,
  input  logic [4:0]          reg_raddr,
  output logic [31:0]         reg_rdata,
  output logic                wgt_we,
  output logic [WGT_AW-1:0]   wgt_addr,
  output logic [7:0]          wgt_data,
  output logic                bias_we,
  output logic [BIAS_AW-1:0]  bias_addr,
  output logic [15:0]         bias_data,
  output logic                img_we,
  output logic [PIX_AW-1:0]   img_addr,
  output logic [7:0]          img_data,
  output logic                core_start,
  input  logic                core_done,
  input  logic [3:0]          core_result
);

  state_t        state_reg;
  logic          soft_hold_reg;
  logic          done_reg;
  logic [3:0]    result_reg;

  logic          arm_wr;
  logic          in_load;
  logic          wr_wgt;
  logic          wr_bias;
  logic          wr_pix;
  logic          pix_rearm;
  logic          busy;
  logic          overflow_err;

  logic          wgt_full, bias_full, pix_full;
  logic          wgt_ovf, bias_ovf, pix_ovf;
  logic [WGT_AW-1:0]  wgt_count;
  logic [BIAS_AW-1:0] bias_count;
  logic [PIX_AW-1:0]  pix_count;

  // While the soft-reset bit is held, every write other than SOFTRST is inert.
  assign arm_wr    = reg_wr && !soft_hold_reg && (reg_waddr == OFS_CTRL) && reg_wdata[0];
  assign in_load   = (state_reg == ST_LOAD) && !soft_hold_reg;
  assign wr_wgt    = reg_wr && in_load && (reg_waddr == OFS_WGT);
  assign wr_bias   = reg_wr && in_load && (reg_waddr == OFS_BIAS);
  assign wr_pix    = reg_wr && in_load && (reg_waddr == OFS_PIX);
  assign pix_rearm = arm_wr && (state_reg == ST_DONE);

  assign busy         = (state_reg == ST_LAUNCH) || (state_reg == ST_RUN);
  assign overflow_err = wgt_ovf | bias_ovf | pix_ovf;

  lenet_stream_ch #(.DEPTH(N_WGT), .AW(WGT_AW), .DW(8)) u_wgt (
    .clk      (ACLK),
    .rst      (ARESET),
    .clr      (soft_hold_reg),
    .clr_cnt  (1'b0),
    .push     (wr_wgt),
    .din      (reg_wdata[7:0]),
    .we       (wgt_we),
    .addr     (wgt_addr),
    .data     (wgt_data),
    .count    (wgt_count),
    .full     (wgt_full),
    .overflow (wgt_ovf)
  );

  lenet_stream_ch #(.DEPTH(N_BIAS), .AW(BIAS_AW), .DW(16)) u_bias (
    .clk      (ACLK),
    .rst      (ARESET),
    .clr      (soft_hold_reg),
    .clr_cnt  (1'b0),
    .push     (wr_bias),
    .din      (reg_wdata[15:0]),
    .we       (bias_we),
    .addr     (bias_addr),
    .data     (bias_data),
    .count    (bias_count),
    .full     (bias_full),
    .overflow (bias_ovf)
  );

  // Only the image channel is rewound on re-arm; the network stays resident.
  lenet_stream_ch #(.DEPTH(N_PIX), .AW(PIX_AW), .DW(8)) u_pix (
    .clk      (ACLK),
    .rst      (ARESET),
    .clr      (soft_hold_reg),
    .clr_cnt  (pix_rearm),
    .push     (wr_pix),
    .din      (reg_wdata[7:0]),
    .we       (img_we),
    .addr     (img_addr),
    .data     (img_data),
    .count    (pix_count),
    .full     (pix_full),
    .overflow (pix_ovf)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      soft_hold_reg <= 1'b0;
    end else if (reg_wr && (reg_waddr == OFS_SOFTRST)) begin
      soft_hold_reg <= reg_wdata[0];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg  <= ST_IDLE;
      done_reg   <= 1'b0;
      result_reg <= 4'd0;
      core_start <= 1'b0;
    end else if (soft_hold_reg) begin
      state_reg  <= ST_IDLE;
      done_reg   <= 1'b0;
      result_reg <= 4'd0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arm_wr) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          // core_start rises together with LAUNCH so the pulse matches the state.
          if (wgt_full && bias_full && pix_full) begin
            state_reg  <= ST_LAUNCH;
            core_start <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (core_done) begin
            result_reg <= core_result;
            done_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm_wr) begin
            done_reg  <= 1'b0;
            state_reg <= ST_LOAD;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Reads sample the current registers, so a same-cycle write is seen only afterwards.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      reg_rdata <= 32'd0;
    end else if (soft_hold_reg) begin
      reg_rdata <= 32'd0;
    end else if (reg_rd) begin
      case (reg_raddr)
        OFS_STATUS: reg_rdata <= pack_status(wgt_full, bias_full, pix_full, busy, overflow_err);
        OFS_DONE:   reg_rdata <= {31'd0, done_reg};
        OFS_RESULT: reg_rdata <= {28'd0, result_reg};
        default:    reg_rdata <= 32'd0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{reg_wdata[31:16], wgt_count, bias_count, pix_count};

endmodule

// File: tb/tb_lenet_load_ctrl.sv
// Directed-plus-random bench for lenet_load_ctrl with a behavioural model of
// the load/launch/result sequence and captured buffer contents.
module tb_lenet_load_ctrl;

  localparam int NW = 3220;
  localparam int NB = 10;
  localparam int NP = 784;

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_WGT     = 5'h04;
  localparam logic [4:0] A_BIAS    = 5'h08;
  localparam logic [4:0] A_PIX     = 5'h0C;
  localparam logic [4:0] A_STATUS  = 5'h10;
  localparam logic [4:0] A_DONE    = 5'h14;
  localparam logic [4:0] A_RESULT  = 5'h18;
  localparam logic [4:0] A_SOFTRST = 5'h1C;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_BUSY = 2;
  localparam int P_DONE = 3;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        reg_wr = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_rd = 1'b0;
  logic [4:0]  reg_raddr = '0;
  logic [31:0] reg_rdata;
  logic        wgt_we;
  logic [11:0] wgt_addr;
  logic [7:0]  wgt_data;
  logic        bias_we;
  logic [3:0]  bias_addr;
  logic [15:0] bias_data;
  logic        img_we;
  logic [9:0]  img_addr;
  logic [7:0]  img_data;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [3:0]  core_result = '0;

  always #5 ACLK = ~ACLK;

  lenet_load_ctrl #(.N_WGT(NW), .N_BIAS(NB), .N_PIX(NP)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .reg_wr      (reg_wr),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .reg_rd      (reg_rd),
    .reg_raddr   (reg_raddr),
    .reg_rdata   (reg_rdata),
    .wgt_we      (wgt_we),
    .wgt_addr    (wgt_addr),
    .wgt_data    (wgt_data),
    .bias_we     (bias_we),
    .bias_addr   (bias_addr),
    .bias_data   (bias_data),
    .img_we      (img_we),
    .img_addr    (img_addr),
    .img_data    (img_data),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Captured buffer traffic
  logic [7:0]  got_wgt [NW];
  logic [15:0] got_bias[NB];
  logic [7:0]  got_pix [NP];
  int n_wgt_we = 0, n_bias_we = 0, n_img_we = 0, n_start = 0;
  int last_wgt_addr = -1, last_bias_addr = -1, last_img_addr = -1;
  int last_img_cyc = 0, start_cyc = 0;

  // Reference model
  logic [7:0]  exp_wgt [NW];
  logic [15:0] exp_bias[NB];
  logic [7:0]  exp_pix [NP];
  int   m_state = P_IDLE;
  int   m_nw = 0, m_nb = 0, m_np = 0;
  int   m_tw = 0, m_tb = 0, m_tp = 0, m_starts = 0;
  bit   m_ovf = 0, m_done = 0;
  logic [3:0] m_res = 4'd0;

  always @(posedge ACLK) cyc++;

  always @(negedge ACLK) begin
    if (wgt_we) begin
      if (int'(wgt_addr) < NW) got_wgt[wgt_addr] = wgt_data;
      n_wgt_we++;
      last_wgt_addr = int'(wgt_addr);
    end
    if (bias_we) begin
      if (int'(bias_addr) < NB) got_bias[bias_addr] = bias_data;
      n_bias_we++;
      last_bias_addr = int'(bias_addr);
    end
    if (img_we) begin
      if (int'(img_addr) < NP) got_pix[img_addr] = img_data;
      n_img_we++;
      last_img_addr = int'(img_addr);
      last_img_cyc = cyc;
    end
    if (core_start) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_nw == NW);
    s[1] = (m_nb == NB);
    s[2] = (m_np == NP);
    s[3] = (m_state == P_BUSY);
    s[4] = m_ovf;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr = 1'b1;
    reg_waddr = a;
    reg_wdata = d;
    @(negedge ACLK);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    reg_rd = 1'b1;
    reg_raddr = a;
    @(negedge ACLK);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic model_reset();
    m_state = P_IDLE;
    m_nw = 0; m_nb = 0; m_np = 0;
    m_ovf = 0; m_done = 0; m_res = 4'd0;
  endtask

  task automatic arm();
    wr(A_CTRL, 32'h1);
    if (m_state == P_IDLE) begin
      m_state = P_LOAD;
    end else if (m_state == P_DONE) begin
      m_done = 0;
      m_np = 0;
      m_state = P_LOAD;
    end
  endtask

  task automatic stream(input int ch, input logic [31:0] d);
    logic [4:0] a;
    case (ch)
      0: a = A_WGT;
      1: a = A_BIAS;
      default: a = A_PIX;
    endcase
    wr(a, d);
    if (m_state == P_LOAD) begin
      case (ch)
        0: if (m_nw < NW) begin exp_wgt[m_nw] = d[7:0]; m_nw++; m_tw++; end else m_ovf = 1;
        1: if (m_nb < NB) begin exp_bias[m_nb] = d[15:0]; m_nb++; m_tb++; end else m_ovf = 1;
        default: if (m_np < NP) begin exp_pix[m_np] = d[7:0]; m_np++; m_tp++; end else m_ovf = 1;
      endcase
      if (m_nw == NW && m_nb == NB && m_np == NP) begin
        m_state = P_BUSY;
        m_starts++;
      end
    end
  endtask

  // Random interleaving of the three streams; a pixel always completes the load.
  task automatic load_random(input int want_w, input int want_b, input int want_p);
    int rw, rb, rp, ch;
    rw = want_w; rb = want_b; rp = want_p;
    while (rw + rb + rp > 0) begin
      ch = int'($urandom_range(0, 2));
      if (ch == 0 && rw == 0) continue;
      if (ch == 1 && rb == 0) continue;
      if (ch == 2 && (rp == 0 || (rp == 1 && rw + rb > 0))) continue;
      stream(ch, $urandom);
      if (ch == 0) rw--; else if (ch == 1) rb--; else rp--;
      if ($urandom_range(0, 7) == 0) @(negedge ACLK);
    end
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (n_start < m_starts && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    repeat (3) @(negedge ACLK);
    check({tag, "_nstart"}, 32'(n_start), 32'(m_starts));
    check({tag, "_start_lat"}, 32'(start_cyc - last_img_cyc), 32'd1);
  endtask

  task automatic pulse_done(input logic [3:0] r);
    core_done = 1'b1;
    core_result = r;
    @(negedge ACLK);
    core_done = 1'b0;
    core_result = 4'd0;
    if (m_state == P_BUSY) begin
      m_done = 1;
      m_res = r;
      m_state = P_DONE;
    end
  endtask

  task automatic poll_done(input string tag);
    logic [31:0] v;
    int k;
    k = 0;
    do begin
      rd(A_DONE, v);
      k++;
    end while (v[0] !== 1'b1 && k < 20);
    check(tag, v, {31'd0, m_done});
  endtask

  task automatic check_mem(input string tag, input int ch);
    int bad;
    bad = 0;
    if (ch == 0) begin
      for (int i = 0; i < NW; i++) if (got_wgt[i] !== exp_wgt[i]) bad++;
    end else if (ch == 1) begin
      for (int i = 0; i < NB; i++) if (got_bias[i] !== exp_bias[i]) bad++;
    end else begin
      for (int i = 0; i < NP; i++) if (got_pix[i] !== exp_pix[i]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [3:0]  r;

    repeat (3) @(negedge ACLK);
    check("rst_we_start", 32'({wgt_we, bias_we, img_we, core_start}), 32'd0);
    check("rst_addr", 32'({wgt_addr, bias_addr, img_addr}), 32'd0);
    check("rst_data", 32'({wgt_data, bias_data, img_data}), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    ARESET = 1'b0;
    model_reset();
    @(negedge ACLK);

    wr(A_SOFTRST, 32'h1);
    wr(A_SOFTRST, 32'h0);
    rd(A_STATUS, v);  check("status_init", v, 32'h00);
    rd(A_DONE, v);    check("done_init", v, 32'd0);
    rd(A_SOFTRST, v); check("wo_reads_zero", v, 32'd0);

    stream(0, $urandom);
    repeat (3) @(negedge ACLK);
    check("idle_drop", 32'(n_wgt_we), 32'(m_tw));

    // First full network + image load
    arm();
    load_random(NW, NB, NP);
    wait_start("load1");
    check("last_wgt_addr", 32'(last_wgt_addr), 32'd3219);
    check("last_bias_addr", 32'(last_bias_addr), 32'd9);
    check("last_img_addr", 32'(last_img_addr), 32'd783);
    check("n_wgt_we", 32'(n_wgt_we), 32'(m_tw));
    check("n_bias_we", 32'(n_bias_we), 32'(m_tb));
    check("n_img_we", 32'(n_img_we), 32'(m_tp));
    check_mem("wgt_mem", 0);
    check_mem("bias_mem", 1);
    check_mem("pix_mem1", 2);
    rd(A_STATUS, v);  check("status_launch", v, exp_status());

    stream(0, $urandom);
    arm();
    repeat (3) @(negedge ACLK);
    check("run_ignore_we", 32'(n_wgt_we), 32'(m_tw));
    rd(A_STATUS, v);  check("status_run", v, exp_status());

    pulse_done(4'd7);
    poll_done("done_poll1");
    rd(A_RESULT, v);  check("result1", v, 32'(m_res));
    rd(A_STATUS, v);  check("status_done1", v, exp_status());

    // Arm with a same-cycle read of DONE: the read sees the pre-write value
    reg_wr = 1'b1; reg_waddr = A_CTRL; reg_wdata = 32'h1;
    reg_rd = 1'b1; reg_raddr = A_DONE;
    @(negedge ACLK);
    reg_wr = 1'b0; reg_rd = 1'b0;
    check("rw_same_cycle", reg_rdata, 32'd1);
    m_done = 0; m_np = 0; m_state = P_LOAD;
    rd(A_DONE, v);    check("done_cleared", v, 32'd0);
    rd(A_STATUS, v);  check("status_rearm", v, exp_status());

    stream(0, $urandom);
    repeat (3) @(negedge ACLK);
    check("ovf_no_we", 32'(n_wgt_we), 32'(m_tw));
    rd(A_STATUS, v);  check("status_ovf", v, exp_status());

    // Second image only
    load_random(0, 0, NP);
    wait_start("load2");
    check("no_wgt_rewrite", 32'(n_wgt_we), 32'(m_tw));
    check_mem("pix_mem2", 2);
    rd(A_STATUS, v);  check("status_launch2", v, exp_status());

    r = 4'($urandom_range(0, 15));
    pulse_done(r);
    poll_done("done_poll2");
    pulse_done(~r);
    repeat (2) @(negedge ACLK);
    rd(A_RESULT, v);  check("result2_kept", v, 32'(m_res));
    rd(A_STATUS, v);  check("status_ovf_sticky", v, exp_status());

    // Third launch, then hard reset while the core runs
    arm();
    load_random(0, 0, NP);
    wait_start("load3");
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
    pulse_done(4'd5);
    repeat (10) @(negedge ACLK);
    rd(A_DONE, v);    check("done_after_areset", v, 32'd0);
    rd(A_RESULT, v);  check("result_after_areset", v, 32'd0);
    rd(A_STATUS, v);  check("status_after_areset", v, exp_status());
    check("no_start_after_areset", 32'(n_start), 32'(m_starts));

    // Writes while the soft reset is held have no effect
    wr(A_SOFTRST, 32'h1);
    wr(A_CTRL, 32'h1);
    wr(A_WGT, $urandom);
    rd(A_STATUS, v);  check("softrst_read_zero", v, 32'd0);
    wr(A_SOFTRST, 32'h0);
    stream(0, $urandom);
    repeat (3) @(negedge ACLK);
    check("softrst_hold_we", 32'(n_wgt_we), 32'(m_tw));
    rd(A_STATUS, v);  check("status_after_softrst", v, exp_status());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
